mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-003 SHALL have port MEM_V  in  1  upstream instruction valid.
REQ-004 SHALL have port MEM_Cst  in  19  control store: [0] reg wen, [1] load, [2] store, [4:3] size (00 B, 01 H, 10 W, 11 D), [5] unsigned load, [17] W-op.
REQ-005 SHALL have port MEM_ALU_RES  in  64  ALU result; the effective address for loads and stores.
REQ-006 SHALL have port MEM_STD  in  64  store data (rs2).
REQ-007 SHALL have ports MEM_IR (32), MEM_NPC (64), MEM_PC_MUX (1), MEM_Target_Address (64)  in  passed through to WB_*.
REQ-008 SHALL have ports DMEM_REQ (1), DMEM_WE (1), DMEM_ADDR (64, 8-byte aligned), DMEM_WDATA (64), DMEM_BE (8)  out  data-memory request.
REQ-009 SHALL have ports DMEM_RDATA (64), DMEM_ACK (1)  in  data-memory response.
REQ-010 SHALL have ports WB_V, WB_Cst, WB_RES, WB_IR, WB_NPC, WB_PC_MUX, WB_Target_Address  out  registered writeback latch.
REQ-011 SHALL have ports MEM_LAM, MEM_SAM  out  1  registered load/store address-misaligned flags, aligned with WB_V.
REQ-012 SHALL have port V_MEM_STALL  out  1  combinational; upstream holds all MEM_* inputs while it is high.

Function
REQ-013 FSM SHALL have states IDLE and WAIT.
REQ-014 IDLE, MEM_V=1, not load/store: latch into WB_* next edge, WB_V=1, WB_RES=MEM_ALU_RES; latency 1.
REQ-015 IDLE, MEM_V=1, load or store, aligned: DMEM_REQ=1 combinationally, V_MEM_STALL=1, go to WAIT.
REQ-016 WAIT: DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_BE and DMEM_WDATA held stable; V_MEM_STALL=1; WB_V=0 until the ACK.
REQ-017 DMEM_ACK=1 in WAIT: latch result, WB_V=1 next edge, return to IDLE, V_MEM_STALL=0 that cycle.
REQ-018 DMEM_ACK=1 in the same cycle as the IDLE request: complete with no WAIT (1-cycle latency).
REQ-019 DMEM_ACK while DMEM_REQ=0 SHALL be ignored.
REQ-020 DMEM_ADDR = {ALU_RES[63:3],3'b0}; byte lane offset o = ALU_RES[2:0].
REQ-021 DMEM_BE = (size mask 0x01/0x03/0x0F/0xFF) << o.
REQ-022 DMEM_WDATA = MEM_STD << (8*o).
REQ-023 Load: WB_RES = (DMEM_RDATA >> 8*o), truncated to size, sign-extended unless Cst[5]=1.
REQ-024 Store: WB_RES = MEM_ALU_RES.
REQ-025 MEM_V=0: WB_V=0 next edge; no request issued.

Reset
REQ-026 RESET=1: state IDLE, WB_V=0, all WB_* = 0, MEM_LAM=MEM_SAM=0, DMEM_REQ=0 from the next edge.
REQ-027 RESET during WAIT abandons the access; a late DMEM_ACK is ignored per REQ-019.

Configuration
REQ-028 With MEM_MISALIGN_TRAP_EN defined: an access with ALU_RES not size-aligned issues no request, completes in 1 cycle with WB_V=1 and MEM_LAM (load) or MEM_SAM (store)=1, and WB_Cst[0] forced to 0.
REQ-029 Without MEM_MISALIGN_TRAP_EN: MEM_LAM=MEM_SAM=0 constant; misaligned accesses are issued per REQ-020..023 with lanes beyond byte 7 dropped.

Verification
REQ-030 ADD, MEM_V=1 -> WB_V=1 next cycle, WB_RES=MEM_ALU_RES, DMEM_REQ never high.
REQ-031 LB at addr 0x1003, RDATA=0x00000000_80000000, ACK after 3 cycles -> BE=0x08, stall 3 cycles, WB_RES=0xFFFFFFFF_FFFFFF80; LBU gives 0x80.
REQ-032 SH at 0x2006, STD=0xABCD -> WE=1, BE=0xC0, WDATA=0xABCD0000_00000000.
REQ-033 LW at 0x1002 with macro -> no request, MEM_LAM=1, WB_V=1, reg wen 0; without macro -> request with BE=0x3C.
REQ-034 RESET asserted during WAIT, ACK arrives one cycle later -> WB_V stays 0, DMEM_REQ=0, state IDLE.
REQ-035 ACK in same cycle as request -> WB_V=1 next cycle, V_MEM_STALL low on the following cycle.

Source files
------------

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one data-memory access per load/store, waits for ACK, aligns load data into the writeback latch.
// Optional macro MEM_MISALIGN_TRAP_EN: trap size-misaligned accesses instead of issuing them.
module mem_stage #(
    parameter int DATA_W = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MEM_V,
    input  logic [18:0]       MEM_Cst,
    input  logic [DATA_W-1:0] MEM_ALU_RES,
    input  logic [DATA_W-1:0] MEM_STD,
    input  logic [31:0]       MEM_IR,
    input  logic [63:0]       MEM_NPC,
    input  logic              MEM_PC_MUX,
    input  logic [63:0]       MEM_Target_Address,
    output logic              DMEM_REQ,
    output logic              DMEM_WE,
    output logic [DATA_W-1:0] DMEM_ADDR,
    output logic [DATA_W-1:0] DMEM_WDATA,
    output logic [DATA_W/8-1:0] DMEM_BE,
    input  logic [DATA_W-1:0] DMEM_RDATA,
    input  logic              DMEM_ACK,
    output logic              WB_V,
    output logic [18:0]       WB_Cst,
    output logic [DATA_W-1:0] WB_RES,
    output logic [31:0]       WB_IR,
    output logic [63:0]       WB_NPC,
    output logic              WB_PC_MUX,
    output logic [63:0]       WB_Target_Address,
    output logic              MEM_LAM,
    output logic              MEM_SAM,
    output logic              V_MEM_STALL
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state_q, state_d;

    logic                    is_load_p0, is_store_p0, uns_p0;
    logic [1:0]              size_p0;
    logic [OFF_W-1:0]        offset_p0;
    logic [LANES-1:0]        mask_p0;
    logic [2*LANES-1:0]      be_wide_p0;
    logic [DATA_W-1:0]       load_shift_p0;
    logic signed [DATA_W-1:0] load_ext_p0;
    logic                    trap_p0, mem_op_p0, req_p0, done_p0;

    logic                    vld_p1, lam_p1, sam_p1, pc_mux_p1;
    logic [18:0]             cst_p1;
    logic [DATA_W-1:0]       res_p1;
    logic [31:0]             ir_p1;
    logic [63:0]             npc_p1, tgt_p1;

    function automatic logic [LANES-1:0] size_mask(input logic [1:0] size);
        logic [LANES-1:0] m;
        m = '0;
        case (size)
            2'b00:   m[0]   = 1'b1;
            2'b01:   m[1:0] = 2'b11;
            2'b10:   m[3:0] = 4'hF;
            default: m      = '1;
        endcase
        return m;
    endfunction

    function automatic logic signed [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] raw,
                                                             input logic [1:0] size,
                                                             input logic uns);
        logic signed [DATA_W-1:0] r;
        case (size)
            2'b00:   r = uns ? {{(DATA_W-8){1'b0}}, raw[7:0]}
                             : {{(DATA_W-8){raw[7]}}, raw[7:0]};
            2'b01:   r = uns ? {{(DATA_W-16){1'b0}}, raw[15:0]}
                             : {{(DATA_W-16){raw[15]}}, raw[15:0]};
            2'b10:   r = uns ? {{(DATA_W-32){1'b0}}, raw[31:0]}
                             : {{(DATA_W-32){raw[31]}}, raw[31:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // ---- p0: decode, lane steering, load alignment ----
    assign is_load_p0  = MEM_Cst[1];
    assign is_store_p0 = MEM_Cst[2];
    assign size_p0     = MEM_Cst[4:3];
    assign uns_p0      = MEM_Cst[5];
    assign offset_p0   = MEM_ALU_RES[OFF_W-1:0];

    assign mask_p0       = size_mask(size_p0);
    assign be_wide_p0    = {{LANES{1'b0}}, mask_p0} << offset_p0;
    assign load_shift_p0 = DMEM_RDATA >> {offset_p0, 3'b000};
    assign load_ext_p0   = load_extend(load_shift_p0, size_p0, uns_p0);

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned_p0;

    always_comb begin
        misaligned_p0 = 1'b0;
        case (size_p0)
            2'b00:   misaligned_p0 = 1'b0;
            2'b01:   misaligned_p0 = offset_p0[0];
            2'b10:   misaligned_p0 = |offset_p0[1:0];
            default: misaligned_p0 = |offset_p0;
        endcase
    end

    assign trap_p0 = MEM_V & (is_load_p0 | is_store_p0) & misaligned_p0;
`else
    assign trap_p0 = 1'b0;
`endif

    assign mem_op_p0 = MEM_V & (is_load_p0 | is_store_p0) & ~trap_p0;

    // Inputs are held by upstream while stalled, so the request is steered straight from them.
    always_comb begin
        state_d = state_q;
        req_p0  = 1'b0;
        done_p0 = 1'b0;
        case (state_q)
            IDLE: begin
                req_p0 = mem_op_p0;
                if (mem_op_p0) begin
                    done_p0 = DMEM_ACK;
                    if (!DMEM_ACK) state_d = WAIT;
                end else begin
                    done_p0 = MEM_V;
                end
            end
            WAIT: begin
                req_p0  = 1'b1;
                done_p0 = DMEM_ACK;
                if (DMEM_ACK) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // An access in flight at reset is abandoned, not re-presented to memory.
        if (RESET) begin
            req_p0  = 1'b0;
            done_p0 = 1'b0;
        end
    end

    assign DMEM_REQ    = req_p0;
    assign DMEM_WE     = req_p0 & is_store_p0;
    assign DMEM_ADDR   = {MEM_ALU_RES[DATA_W-1:OFF_W], {OFF_W{1'b0}}};
    assign DMEM_BE     = be_wide_p0[LANES-1:0];
    assign DMEM_WDATA  = MEM_STD << {offset_p0, 3'b000};
    assign V_MEM_STALL = req_p0 & ~DMEM_ACK;

    // ---- p1: writeback latch ----
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            vld_p1    <= 1'b0;
            lam_p1    <= 1'b0;
            sam_p1    <= 1'b0;
            cst_p1    <= '0;
            res_p1    <= '0;
            ir_p1     <= '0;
            npc_p1    <= '0;
            pc_mux_p1 <= 1'b0;
            tgt_p1    <= '0;
        end else begin
            state_q <= state_d;
            vld_p1  <= done_p0;
            lam_p1  <= done_p0 & trap_p0 & is_load_p0;
            sam_p1  <= done_p0 & trap_p0 & is_store_p0;
            if (done_p0) begin
                cst_p1    <= trap_p0 ? {MEM_Cst[18:1], 1'b0} : MEM_Cst;
                res_p1    <= (is_load_p0 && !trap_p0) ? load_ext_p0 : MEM_ALU_RES;
                ir_p1     <= MEM_IR;
                npc_p1    <= MEM_NPC;
                pc_mux_p1 <= MEM_PC_MUX;
                tgt_p1    <= MEM_Target_Address;
            end
        end
    end

    assign WB_V              = vld_p1;
    assign WB_Cst            = cst_p1;
    assign WB_RES            = res_p1;
    assign WB_IR             = ir_p1;
    assign WB_NPC            = npc_p1;
    assign WB_PC_MUX         = pc_mux_p1;
    assign WB_Target_Address = tgt_p1;
    assign MEM_LAM           = lam_p1;
    assign MEM_SAM           = sam_p1;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected writeback records, a negedge monitor pops and compares.
module tb_mem_stage;

    logic        CLK, RESET, MEM_V, MEM_PC_MUX;
    logic [18:0] MEM_Cst;
    logic [63:0] MEM_ALU_RES, MEM_STD, MEM_NPC, MEM_Target_Address;
    logic [31:0] MEM_IR;
    logic        DMEM_REQ, DMEM_WE, DMEM_ACK;
    logic [63:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
    logic [7:0]  DMEM_BE;
    logic        WB_V, WB_PC_MUX, MEM_LAM, MEM_SAM, V_MEM_STALL;
    logic [18:0] WB_Cst;
    logic [63:0] WB_RES, WB_NPC, WB_Target_Address;
    logic [31:0] WB_IR;

    typedef struct packed {
        logic [63:0] res;
        logic [18:0] cst;
        logic        lam;
        logic        sam;
        logic [31:0] ir;
        logic [63:0] npc;
        logic        pc_mux;
        logic [63:0] tgt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] tag = 0;

    mem_stage dut (
        .CLK(CLK), .RESET(RESET), .MEM_V(MEM_V), .MEM_Cst(MEM_Cst),
        .MEM_ALU_RES(MEM_ALU_RES), .MEM_STD(MEM_STD), .MEM_IR(MEM_IR),
        .MEM_NPC(MEM_NPC), .MEM_PC_MUX(MEM_PC_MUX), .MEM_Target_Address(MEM_Target_Address),
        .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
        .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE), .DMEM_RDATA(DMEM_RDATA),
        .DMEM_ACK(DMEM_ACK), .WB_V(WB_V), .WB_Cst(WB_Cst), .WB_RES(WB_RES),
        .WB_IR(WB_IR), .WB_NPC(WB_NPC), .WB_PC_MUX(WB_PC_MUX),
        .WB_Target_Address(WB_Target_Address), .MEM_LAM(MEM_LAM), .MEM_SAM(MEM_SAM),
        .V_MEM_STALL(V_MEM_STALL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: every presented writeback must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (!RESET && WB_V) begin
            if (exp_q.size() == 0) begin
                chk1("unexpected_wb", WB_V, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk64("wb_res", WB_RES, e.res);
                chk64("wb_cst", 64'(WB_Cst), 64'(e.cst));
                chk1("mem_lam", MEM_LAM, e.lam);
                chk1("mem_sam", MEM_SAM, e.sam);
                chk64("wb_ir", 64'(WB_IR), 64'(e.ir));
                chk64("wb_npc", WB_NPC, e.npc);
                chk1("wb_pc_mux", WB_PC_MUX, e.pc_mux);
                chk64("wb_tgt", WB_Target_Address, e.tgt);
            end
        end else if (!RESET) begin
            chk1("lam_idle", MEM_LAM, 1'b0);
            chk1("sam_idle", MEM_SAM, 1'b0);
        end
    end

    task automatic do_op(input logic [18:0] cst, input logic [63:0] alu, input logic [63:0] std,
                         input logic [63:0] rdata, input int ack_wait, input logic exp_req,
                         input logic [63:0] exp_addr, input logic [7:0] exp_be,
                         input logic [63:0] exp_wdata, input logic [63:0] exp_res,
                         input logic exp_lam, input logic exp_sam, input logic exp_wen);
        exp_t e;
        tag      = tag + 1;
        e.res    = exp_res;
        e.cst    = {cst[18:1], exp_wen};
        e.lam    = exp_lam;
        e.sam    = exp_sam;
        e.ir     = 32'hA000_0000 + tag;
        e.npc    = 64'h0000_0000_1000_0000 + 64'(tag);
        e.pc_mux = tag[0];
        e.tgt    = 64'hBEEF_0000_0000_0000 | 64'(tag);
        exp_q.push_back(e);

        @(posedge CLK); #1;
        MEM_V = 1'b1; MEM_Cst = cst; MEM_ALU_RES = alu; MEM_STD = std;
        MEM_IR = e.ir; MEM_NPC = e.npc; MEM_PC_MUX = e.pc_mux; MEM_Target_Address = e.tgt;
        DMEM_RDATA = rdata;
        DMEM_ACK = exp_req && (ack_wait == 0);
        @(negedge CLK);
        chk1("dmem_req", DMEM_REQ, exp_req);
        chk1("stall_c0", V_MEM_STALL, exp_req && (ack_wait != 0));
        if (exp_req) begin
            chk64("dmem_addr", DMEM_ADDR, exp_addr);
            chk64("dmem_be", 64'(DMEM_BE), 64'(exp_be));
            chk1("dmem_we", DMEM_WE, cst[2]);
            chk64("dmem_wdata", DMEM_WDATA, exp_wdata);
            for (int k = 1; k <= ack_wait; k++) begin
                @(posedge CLK); #1;
                DMEM_ACK = (k == ack_wait);
                @(negedge CLK);
                chk1("req_hold", DMEM_REQ, 1'b1);
                chk64("be_hold", 64'(DMEM_BE), 64'(exp_be));
                chk64("addr_hold", DMEM_ADDR, exp_addr);
                chk64("wdata_hold", DMEM_WDATA, exp_wdata);
                chk1("wb_v_wait", WB_V, 1'b0);
                chk1("stall_wait", V_MEM_STALL, k != ack_wait);
            end
        end
        @(posedge CLK); #1;
        MEM_V = 1'b0; DMEM_ACK = 1'b0;
        @(negedge CLK);
        chk1("wb_v_done", WB_V, 1'b1);
        chk1("req_after", DMEM_REQ, 1'b0);
        chk1("stall_after", V_MEM_STALL, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; MEM_V = 1'b0; MEM_Cst = '0; MEM_ALU_RES = '0; MEM_STD = '0;
        MEM_IR = '0; MEM_NPC = '0; MEM_PC_MUX = 1'b0; MEM_Target_Address = '0;
        DMEM_RDATA = '0; DMEM_ACK = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk1("rst_wb_v", WB_V, 1'b0);
        chk64("rst_wb_res", WB_RES, 64'h0);
        chk64("rst_wb_cst", 64'(WB_Cst), 64'h0);
        chk64("rst_wb_ir", 64'(WB_IR), 64'h0);
        chk1("rst_lam", MEM_LAM, 1'b0);
        chk1("rst_sam", MEM_SAM, 1'b0);
        chk1("rst_req", DMEM_REQ, 1'b0);
        @(posedge CLK); #1;
        RESET = 1'b0;

        // ALU op (W-op flag set): passes straight through, no request
        do_op(19'h20001, 64'h1234_5678_9ABC_DEF0, 64'h0, 64'h0, 0, 1'b0,
              64'h0, 8'h00, 64'h0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 1'b1);

        // Stray ACK with no request outstanding
        @(posedge CLK); #1;
        DMEM_ACK = 1'b1;
        @(negedge CLK);
        chk1("stray_ack_req", DMEM_REQ, 1'b0);
        chk1("stray_ack_stall", V_MEM_STALL, 1'b0);
        @(posedge CLK); #1;
        DMEM_ACK = 1'b0;
        @(negedge CLK);
        chk1("stray_ack_wb_v", WB_V, 1'b0);

        // LB 0x1003, ACK after 3 stall cycles
        do_op(19'h00003, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 3, 1'b1,
              64'h1000, 8'h08, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b0, 1'b1);
        // LBU same data
        do_op(19'h00023, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 1, 1'b1,
              64'h1000, 8'h08, 64'h0, 64'h0000_0000_0000_0080, 1'b0, 1'b0, 1'b1);
        // SH 0x2006, ACK in the request cycle
        do_op(19'h0000C, 64'h2006, 64'h0000_0000_0000_ABCD, 64'h0, 0, 1'b1,
              64'h2000, 8'hC0, 64'hABCD_0000_0000_0000, 64'h2006, 1'b0, 1'b0, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
        do_op(19'h00013, 64'h1002, 64'h0, 64'h0, 0, 1'b0,
              64'h0, 8'h00, 64'h0, 64'h1002, 1'b1, 1'b0, 1'b0);
`else
        do_op(19'h00013, 64'h1002, 64'h0, 64'h0000_DEAD_BEEF_0000, 2, 1'b1,
              64'h1000, 8'h3C, 64'h0, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 1'b0, 1'b1);
`endif
        // LD aligned, single-cycle completion
        do_op(19'h0001B, 64'h3000, 64'h0, 64'h8877_6655_4433_2211, 0, 1'b1,
              64'h3000, 8'hFF, 64'h0, 64'h8877_6655_4433_2211, 1'b0, 1'b0, 1'b1);
        // LH 0x4002 signed
        do_op(19'h0000B, 64'h4002, 64'h0, 64'h0000_0000_8001_0000, 1, 1'b1,
              64'h4000, 8'h0C, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 1'b0, 1'b1);
        // SW 0x5004
        do_op(19'h00014, 64'h5004, 64'hFFFF_FFFF_1234_5678, 64'h0, 2, 1'b1,
              64'h5000, 8'hF0, 64'h1234_5678_0000_0000, 64'h5004, 1'b0, 1'b0, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
        do_op(19'h0001C, 64'h6001, 64'h1122_3344_5566_7788, 64'h0, 0, 1'b0,
              64'h0, 8'h00, 64'h0, 64'h6001, 1'b0, 1'b1, 1'b0);
`else
        // SD 0x6001: top lane falls off the word
        do_op(19'h0001C, 64'h6001, 64'h1122_3344_5566_7788, 64'h0, 1, 1'b1,
              64'h6000, 8'hFE, 64'h2233_4455_6677_8800, 64'h6001, 1'b0, 1'b0, 1'b0);
`endif
        // LWU 0x7004
        do_op(19'h00033, 64'h7004, 64'h0, 64'hF000_0000_0000_0000, 0, 1'b1,
              64'h7000, 8'hF0, 64'h0, 64'h0000_0000_F000_0000, 1'b0, 1'b0, 1'b1);

        // Reset while waiting, then a late ACK
        @(posedge CLK); #1;
        MEM_V = 1'b1; MEM_Cst = 19'h00003; MEM_ALU_RES = 64'h1003; DMEM_ACK = 1'b0;
        @(negedge CLK);
        chk1("rw_req", DMEM_REQ, 1'b1);
        @(posedge CLK); #1;
        RESET = 1'b1; MEM_V = 1'b0;
        @(negedge CLK);
        chk1("rw_req_in_reset", DMEM_REQ, 1'b0);
        @(posedge CLK); #1;
        RESET = 1'b0; DMEM_ACK = 1'b1;
        @(negedge CLK);
        chk1("rw_late_ack_req", DMEM_REQ, 1'b0);
        chk1("rw_late_ack_stall", V_MEM_STALL, 1'b0);
        chk1("rw_wb_v0", WB_V, 1'b0);
        @(posedge CLK); #1;
        DMEM_ACK = 1'b0;
        @(negedge CLK);
        chk1("rw_wb_v1", WB_V, 1'b0);

        // Back in IDLE: a fresh load behaves normally
        do_op(19'h0001B, 64'h8008, 64'h0, 64'h0102_0304_0506_0708, 1, 1'b1,
              64'h8008, 8'hFF, 64'h0, 64'h0102_0304_0506_0708, 1'b0, 1'b0, 1'b1);

        repeat (3) @(negedge CLK);
        chk64("drain", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
